// File: rtl/cache_mem_pkg.sv
// Shared defaults, line geometry and FSM encoding for the cache line memory responder.
package cache_mem_pkg;

  localparam int ADDR_W_DEF     = 6;
  localparam int DATA_W_DEF     = 32;
  localparam int WORDS_PER_LINE = 4;
  localparam int OFF_W          = $clog2(WORDS_PER_LINE);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_WAIT  = 2'd1,
    ST_RD_BURST = 2'd2,
    ST_WR_BURST = 2'd3
  } state_e;

  // Critical-word-first order: the offset simply wraps within the line.
  function automatic logic [OFF_W-1:0] wrap_inc(input logic [OFF_W-1:0] off);
    return off + OFF_W'(1);
  endfunction

endpackage

// File: rtl/cache_mem_responder_if.sv
// Request, write-back and fill channels between a cache (master) and the responder (slave).
interface cache_mem_responder_if
  import cache_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;

  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              wr_done;

  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic [OFF_W-1:0]  rd_offset;
  logic              rd_last;

  modport master (
    output req_valid, req_write, req_addr, wr_valid, wr_data, rd_ready,
    input  req_ready, wr_ready, wr_done, rd_valid, rd_data, rd_offset, rd_last
  );

  modport slave (
    input  req_valid, req_write, req_addr, wr_valid, wr_data, rd_ready,
    output req_ready, wr_ready, wr_done, rd_valid, rd_data, rd_offset, rd_last
  );

endinterface

// File: rtl/mem_array.sv
// Single-port word storage: synchronous write, combinational read of the same address.
module mem_array #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/cache_mem_responder.sv
// Line-granular memory responder: wrapping write-back bursts and latency-delayed,
// critical-word-first fill bursts with back-pressure.
module cache_mem_responder
  import cache_mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  cache_mem_responder_if.slave bus,
  output logic                 busy
);

  localparam int         BASE_W   = ADDR_W - OFF_W;
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [BASE_W-1:0] base_q, base_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [1:0]        beat_q, beat_d;
  logic [3:0]        lat_q, lat_d;
  logic              req_ready_q, req_ready_d;
  logic              wr_ready_q, wr_ready_d;
  logic              wr_done_q, wr_done_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [OFF_W-1:0]  rd_offset_q, rd_offset_d;

  logic              accept;
  logic              wr_xfer;
  logic              rd_xfer;
  logic              load_beat;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  assign accept  = bus.req_valid && req_ready_q;
  assign wr_xfer = (state_q == ST_WR_BURST) && bus.wr_valid;
  assign rd_xfer = rd_valid_q && bus.rd_ready;
  assign mem_we  = wr_xfer && !reset;

  // off_q always addresses the next word to write or to stage as a fill beat.
  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  ({base_q, off_q}),
    .wdata_i (bus.wr_data),
    .rdata_o (mem_rdata)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    off_d       = off_q;
    beat_d      = beat_q;
    lat_d       = lat_q;
    req_ready_d = req_ready_q;
    wr_ready_d  = wr_ready_q;
    wr_done_d   = 1'b0;
    rd_valid_d  = rd_valid_q;
    rd_last_d   = rd_last_q;
    busy_d      = busy_q;
    rd_data_d   = rd_data_q;
    rd_offset_d = rd_offset_q;
    load_beat   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          base_d      = bus.req_addr[ADDR_W-1:OFF_W];
          off_d       = bus.req_addr[OFF_W-1:0];
          beat_d      = 2'd0;
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          if (bus.req_write) begin
            state_d    = ST_WR_BURST;
            wr_ready_d = 1'b1;
          end else begin
            state_d = ST_RD_WAIT;
            lat_d   = LAT_LOAD;
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      ST_RD_WAIT: begin
        if (lat_q == 4'd0) begin
          state_d   = ST_RD_BURST;
          load_beat = 1'b1;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      ST_RD_BURST: begin
        if (rd_xfer && rd_last_q) begin
          state_d     = ST_IDLE;
          rd_valid_d  = 1'b0;
          rd_last_d   = 1'b0;
          req_ready_d = 1'b1;
          busy_d      = 1'b0;
        end else if (rd_xfer) begin
          load_beat = 1'b1;
        end else begin
          rd_valid_d = 1'b1;
        end
      end
      ST_WR_BURST: begin
        if (wr_xfer) begin
          off_d  = wrap_inc(off_q);
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            state_d     = ST_IDLE;
            wr_ready_d  = 1'b0;
            wr_done_d   = 1'b1;
            req_ready_d = 1'b1;
            busy_d      = 1'b0;
          end else begin
            wr_ready_d = 1'b1;
          end
        end else begin
          wr_ready_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Stage a fill beat; the 4th staged beat carries rd_last.
    if (load_beat) begin
      rd_valid_d  = 1'b1;
      rd_data_d   = mem_rdata;
      rd_offset_d = off_q;
      rd_last_d   = (beat_q == 2'd3);
      off_d       = wrap_inc(off_q);
      beat_d      = beat_q + 2'd1;
    end else begin
      load_beat = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      off_q       <= '0;
      beat_q      <= 2'd0;
      lat_q       <= 4'd0;
      req_ready_q <= 1'b0;
      wr_ready_q  <= 1'b0;
      wr_done_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      busy_q      <= 1'b0;
      rd_data_q   <= '0;
      rd_offset_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      off_q       <= off_d;
      beat_q      <= beat_d;
      lat_q       <= lat_d;
      req_ready_q <= req_ready_d;
      wr_ready_q  <= wr_ready_d;
      wr_done_q   <= wr_done_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      busy_q      <= busy_d;
      rd_data_q   <= rd_data_d;
      rd_offset_q <= rd_offset_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.wr_ready  = wr_ready_q;
  assign bus.wr_done   = wr_done_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_last   = rd_last_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_offset = rd_offset_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder (LATENCY=3 and LATENCY=1 builds); expected fill
// beats are queued at issue time and checked by an independent monitor.
module tb_cache_mem_responder;

  localparam int AW = 6;
  localparam int DW = 32;

  typedef struct packed {
    logic [1:0]    off;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, sel;
  logic          req_valid, req_write, wr_valid, rd_ready;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] wr_data;
  logic          busy3, busy1;

  logic          req_ready_m, wr_ready_m, wr_done_m, rd_valid_m, rd_last_m, busy_m;
  logic [DW-1:0] rd_data_m;
  logic [1:0]    rd_offset_m;

  int     vectors;
  int     miscompares;
  beat_t  exp_q[$];
  beat_t  mon_b;
  logic   stall_prev;
  beat_t  held;
  logic [127:0] line_a, line_b, line_c, line_d;
  int     n;

  cache_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();
  cache_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  cache_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3), .busy(busy3)
  );
  cache_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .busy(busy1)
  );

  assign bus3.req_valid = req_valid & ~sel;
  assign bus3.req_write = req_write;
  assign bus3.req_addr  = req_addr;
  assign bus3.wr_valid  = wr_valid & ~sel;
  assign bus3.wr_data   = wr_data;
  assign bus3.rd_ready  = rd_ready & ~sel;
  assign bus1.req_valid = req_valid & sel;
  assign bus1.req_write = req_write;
  assign bus1.req_addr  = req_addr;
  assign bus1.wr_valid  = wr_valid & sel;
  assign bus1.wr_data   = wr_data;
  assign bus1.rd_ready  = rd_ready & sel;

  assign req_ready_m = sel ? bus1.req_ready : bus3.req_ready;
  assign wr_ready_m  = sel ? bus1.wr_ready  : bus3.wr_ready;
  assign wr_done_m   = sel ? bus1.wr_done   : bus3.wr_done;
  assign rd_valid_m  = sel ? bus1.rd_valid  : bus3.rd_valid;
  assign rd_last_m   = sel ? bus1.rd_last   : bus3.rd_last;
  assign rd_data_m   = sel ? bus1.rd_data   : bus3.rd_data;
  assign rd_offset_m = sel ? bus1.rd_offset : bus3.rd_offset;
  assign busy_m      = sel ? busy1          : busy3;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!req_ready_m && k < 60) begin
      tick();
      k++;
    end
    if (!req_ready_m) chk("req_ready_timeout", {63'd0, req_ready_m}, 64'd1);
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] a);
    wait_ready();
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic push_line(input logic [1:0] start, input logic [127:0] line);
    beat_t e;
    logic [1:0] o;
    for (int k = 0; k < 4; k++) begin
      o      = start + 2'(k);
      e.off  = o;
      e.data = line[o*32 +: 32];
      e.last = (k == 3);
      exp_q.push_back(e);
    end
  endtask

  task automatic write_line(input logic [AW-1:0] a, input logic [127:0] line, input logic [3:0] gaps);
    issue(1'b1, a);
    for (int i = 0; i < 4; i++) begin
      if (gaps[i]) begin
        wr_valid = 1'b0;
        tick();
      end
      chk("wr_ready", {63'd0, wr_ready_m}, 64'd1);
      wr_valid = 1'b1;
      wr_data  = line[i*32 +: 32];
      tick();
    end
    wr_valid = 1'b0;
    chk("wr_done_pulse", {63'd0, wr_done_m}, 64'd1);
    chk("req_ready_after_wr", {63'd0, req_ready_m}, 64'd1);
    chk("busy_after_wr", {63'd0, busy_m}, 64'd0);
    tick();
    chk("wr_done_width", {63'd0, wr_done_m}, 64'd0);
  endtask

  task automatic read_line(input logic [AW-1:0] a, input int lat, input int stall_at);
    int k;
    issue(1'b0, a);
    k = 0;
    while (!rd_valid_m && k < 20) begin
      tick();
      k++;
    end
    chk("rd_latency", 64'(k), 64'(lat));
    if (stall_at > 0) begin
      repeat (stall_at - 1) tick();
      rd_ready = 1'b0;
      repeat (5) tick();
      rd_ready = 1'b1;
    end
    wait_ready();
    chk("beats_outstanding", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_ready", {63'd0, req_ready_m}, 64'd0);
    chk("rst_wr_ready", {63'd0, wr_ready_m}, 64'd0);
    chk("rst_wr_done", {63'd0, wr_done_m}, 64'd0);
    chk("rst_rd_valid", {63'd0, rd_valid_m}, 64'd0);
    chk("rst_rd_last", {63'd0, rd_last_m}, 64'd0);
    chk("rst_busy", {63'd0, busy_m}, 64'd0);
    chk("rst_rd_data", {32'd0, rd_data_m}, 64'd0);
    chk("rst_rd_offset", {62'd0, rd_offset_m}, 64'd0);
  endtask

  // Monitor: every fill transfer is popped against the scoreboard; stalled beats must hold.
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", {63'd0, rd_valid_m}, 64'd1);
        chk("stall_data", {32'd0, rd_data_m}, {32'd0, held.data});
        chk("stall_offset", {62'd0, rd_offset_m}, {62'd0, held.off});
        chk("stall_last", {63'd0, rd_last_m}, {63'd0, held.last});
      end
      if (rd_valid_m && rd_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL extra_beat: got beat offset %0d data %0h, expected no beat", rd_offset_m, rd_data_m);
        end else begin
          mon_b = exp_q.pop_front();
          chk("rd_offset", {62'd0, rd_offset_m}, {62'd0, mon_b.off});
          chk("rd_data", {32'd0, rd_data_m}, {32'd0, mon_b.data});
          chk("rd_last", {63'd0, rd_last_m}, {63'd0, mon_b.last});
        end
      end
      stall_prev = rd_valid_m && !rd_ready;
      held.data  = rd_data_m;
      held.off   = rd_offset_m;
      held.last  = rd_last_m;
    end
  end

  initial begin
    #100000;
    miscompares++;
    vectors++;
    $display("FAIL watchdog: simulation did not complete, expected completion before 100000");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    vectors = 0; miscompares = 0; stall_prev = 1'b0;
    sel = 1'b0; reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b1;
    line_a = {32'hA333_3333, 32'hA222_2222, 32'hA111_1111, 32'hA000_0000};
    line_b = {32'hB333_0003, 32'hB222_0002, 32'hB111_0001, 32'hB000_0000};
    line_c = {32'hC333_3333, 32'hC222_2222, 32'hC111_1111, 32'hC000_0000};
    line_d = {32'hD333_3333, 32'hD222_2222, 32'hD111_1111, 32'hD000_0000};

    tick(); tick();
    chk_reset_outputs();
    reset = 1'b0;
    tick();
    chk("req_ready_after_reset", {63'd0, req_ready_m}, 64'd1);

    // Write-back 0x14 then fill from offset 0.
    write_line(6'h14, line_a, 4'b0000);
    push_line(2'd0, line_a);
    read_line(6'h14, 3, 0);

    // Wrapped fill from 0x16, with stray wr_valid that must not write.
    wr_valid = 1'b1;
    wr_data  = 32'hDEAD_BEEF;
    push_line(2'd2, line_a);
    read_line(6'h16, 3, 0);
    wr_valid = 1'b0;

    // Five-cycle stall on beat 2.
    push_line(2'd1, line_a);
    read_line(6'h15, 3, 2);

    // req_valid held through a fill; the second request waits until IDLE.
    push_line(2'd1, line_a);
    push_line(2'd3, line_a);
    wait_ready();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 6'h15;
    tick();
    req_addr = 6'h17;
    n = 0;
    while (!req_ready_m && n < 40) begin
      tick();
      n++;
    end
    chk("req_ready_hold_cycles", 64'(n), 64'd7);
    tick();
    req_valid = 1'b0;
    chk("second_accept_busy", {63'd0, busy_m}, 64'd1);
    chk("second_accept_ready", {63'd0, req_ready_m}, 64'd0);
    n = 0;
    while (!rd_valid_m && n < 20) begin
      tick();
      n++;
    end
    chk("second_latency", 64'(n), 64'd3);
    wait_ready();
    chk("beats_outstanding2", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of a gapped write-back to 0x20.
    write_line(6'h20, line_c, 4'b0000);
    issue(1'b1, 6'h20);
    wr_valid = 1'b0; tick();
    wr_valid = 1'b1; wr_data = line_d[31:0]; tick();
    wr_valid = 1'b0; tick();
    wr_valid = 1'b1; wr_data = line_d[63:32]; tick();
    wr_data = 32'hBAD0_BAD0;
    reset = 1'b1;
    tick();
    chk_reset_outputs();
    wr_valid = 1'b0;
    reset = 1'b0;
    tick();
    chk("req_ready_after_midreset", {63'd0, req_ready_m}, 64'd1);
    push_line(2'd0, {line_c[127:64], line_d[63:0]});
    read_line(6'h20, 3, 0);

    // LATENCY=1 build: gapped write of line 0, then wrapped fill from 0x03.
    sel = 1'b1;
    tick();
    write_line(6'h00, line_b, 4'b0101);
    push_line(2'd3, line_b);
    read_line(6'h03, 1, 0);
    sel = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
